axi_rd_master: RTL and testbench

- Single-outstanding AXI4 read master serving the instruction-cache side of the cache/AXI-controller interface.
- Accepts a word address from the cache (a zero address means no request) and issues a single-beat AR transaction.
- Collects the R beat and returns the data with a busy-low strobe that the cache samples.
- Sits between the icache and the top-level AXI bus.

---
 rtl/axi_rd_master.sv | 97 +++++++++
 tb/tb_axi_rd_master.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_master.sv
// Single-outstanding AXI4 read master for the icache: one single-beat AR per nonzero cache address,
// data returned with a one-cycle busy-low strobe; 3-cycle minimum latency, stalls on arready/rvalid hold busy high.
module axi_rd_master #(
  parameter int                ADDR_WIDTH = 32,
  parameter int                DATA_WIDTH = 32,
  parameter int                ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cache_addr_i,
  output logic [DATA_WIDTH-1:0] cache_data_o,
  output logic                  cache_busy_o,
  output logic                  cache_err_o,
  output logic [ID_WIDTH-1:0]   arid_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [ID_WIDTH-1:0]   rid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_AR   = 2'b01;
  localparam logic [1:0] S_R    = 2'b10;
  localparam logic [1:0] S_RESP = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  // rid_i is irrelevant with a single transaction in flight
  logic unused_rid;
  assign unused_rid = ^rid_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cache_addr_i != '0) begin
          addr_d  = cache_addr_i;
          state_d = S_AR;
        end
      end
      S_AR: begin
        if (arready_i) state_d = S_R;
      end
      S_R: begin
        if (rvalid_i) begin
          data_d  = rdata_i;
          err_d   = (rresp_i != 2'b00) | ~rlast_i;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Every output is a decode of registered state, so no AXI input reaches the cache combinationally
  assign arvalid_o    = (state_q == S_AR);
  assign rready_o     = (state_q == S_R);
  assign araddr_o     = addr_q;
  assign cache_busy_o = (state_q != S_RESP);
  assign cache_data_o = (state_q == S_RESP) ? data_q : '0;
  assign cache_err_o  = (state_q == S_RESP) ? err_q : 1'b0;

  assign arid_o    = AXI_ID;
  assign arlen_o   = 8'd0;
  assign arsize_o  = 3'b010;
  assign arburst_o = 2'b01;

endmodule

// File: tb/tb_axi_rd_master.sv
// Directed bench for axi_rd_master: hand-computed expectations checked with immediate assertions.
module tb_axi_rd_master;

  logic        clk;
  logic        rst_n;
  logic [31:0] cache_addr_i;
  logic [31:0] cache_data_o;
  logic        cache_busy_o;
  logic        cache_err_o;
  logic [3:0]  arid_o;
  logic [31:0] araddr_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [3:0]  rid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic        rvalid_i;
  logic        rready_o;

  int n_checks = 0;
  int n_pass   = 0;

  axi_rd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .AXI_ID(4'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cache_addr_i(cache_addr_i), .cache_data_o(cache_data_o),
    .cache_busy_o(cache_busy_o), .cache_err_o(cache_err_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
    .arsize_o(arsize_o), .arburst_o(arburst_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Minimum-latency read starting from IDLE: AR and R accepted on first try
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, input logic last, input logic exp_err);
    cache_addr_i = addr; arready_i = 1'b1; rvalid_i = 1'b1;
    rdata_i = data; rresp_i = resp; rlast_i = last;
    check({tag, "_idle_busy"}, {31'd0, cache_busy_o}, 32'd1);
    tick();
    check({tag, "_ar_vld"}, {31'd0, arvalid_o}, 32'd1);
    check({tag, "_ar_addr"}, araddr_o, addr);
    cache_addr_i = 32'd0;
    tick();
    check({tag, "_r_rdy"}, {31'd0, rready_o}, 32'd1);
    check({tag, "_r_arvld"}, {31'd0, arvalid_o}, 32'd0);
    tick();
    check({tag, "_resp_busy"}, {31'd0, cache_busy_o}, 32'd0);
    check({tag, "_resp_data"}, cache_data_o, data);
    check({tag, "_resp_err"}, {31'd0, cache_err_o}, {31'd0, exp_err});
    rvalid_i = 1'b0;
    tick();
    check({tag, "_post_busy"}, {31'd0, cache_busy_o}, 32'd1);
    check({tag, "_post_data"}, cache_data_o, 32'd0);
    check({tag, "_post_err"}, {31'd0, cache_err_o}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cache_addr_i = '0; arready_i = 1'b0; rid_i = '0;
    rdata_i = '0; rresp_i = '0; rlast_i = 1'b0; rvalid_i = 1'b0;
    #12;
    check("rst_busy", {31'd0, cache_busy_o}, 32'd1);
    check("rst_data", cache_data_o, 32'd0);
    check("rst_err", {31'd0, cache_err_o}, 32'd0);
    check("rst_arvalid", {31'd0, arvalid_o}, 32'd0);
    check("rst_rready", {31'd0, rready_o}, 32'd0);
    check("rst_araddr", araddr_o, 32'd0);
    check("const_arlen", {24'd0, arlen_o}, 32'd0);
    check("const_arsize", {29'd0, arsize_o}, 32'd2);
    check("const_arburst", {30'd0, arburst_o}, 32'd1);
    check("const_arid", {28'd0, arid_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Basic read; rvalid already high during AR must be ignored
    do_read("basic", 32'h1C00_0000, 32'hDEAD_BEEF, 2'b00, 1'b1, 1'b0);

    // AR backpressure: 5 stalled cycles then accept in the 6th
    cache_addr_i = 32'h0000_2000; arready_i = 1'b0; rvalid_i = 1'b1;
    rdata_i = 32'hCAFE_0001; rresp_i = 2'b00; rlast_i = 1'b1;
    tick();
    cache_addr_i = 32'd0;
    for (int i = 0; i < 5; i++) begin
      check("bp_arvalid", {31'd0, arvalid_o}, 32'd1);
      check("bp_araddr", araddr_o, 32'h0000_2000);
      check("bp_busy", {31'd0, cache_busy_o}, 32'd1);
      check("bp_rready", {31'd0, rready_o}, 32'd0);
      tick();
    end
    check("bp_arvalid6", {31'd0, arvalid_o}, 32'd1);
    arready_i = 1'b1;
    tick();
    check("bp_rready", {31'd0, rready_o}, 32'd1);
    tick();
    check("bp_resp_busy", {31'd0, cache_busy_o}, 32'd0);
    check("bp_resp_data", cache_data_o, 32'hCAFE_0001);
    rvalid_i = 1'b0;
    tick();

    // Address change mid-flight, rvalid delayed
    cache_addr_i = 32'h100;
    tick();
    cache_addr_i = 32'h104;
    check("mf_araddr_ar", araddr_o, 32'h100);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("mf_araddr_r", araddr_o, 32'h100);
      check("mf_rready", {31'd0, rready_o}, 32'd1);
      check("mf_busy", {31'd0, cache_busy_o}, 32'd1);
      tick();
    end
    rvalid_i = 1'b1; rdata_i = 32'h1111_0100;
    tick();
    check("mf_resp_busy", {31'd0, cache_busy_o}, 32'd0);
    check("mf_resp_data", cache_data_o, 32'h1111_0100);
    rdata_i = 32'h2222_0104;
    tick();
    check("mf_idle_arvalid", {31'd0, arvalid_o}, 32'd0);
    tick();
    check("mf_ar2_arvalid", {31'd0, arvalid_o}, 32'd1);
    check("mf_ar2_araddr", araddr_o, 32'h104);
    cache_addr_i = 32'd0;
    tick();
    tick();
    check("mf_resp2_data", cache_data_o, 32'h2222_0104);
    rvalid_i = 1'b0;
    tick();

    // Error responses
    do_read("slverr", 32'h0000_3000, 32'h1234_5678, 2'b10, 1'b1, 1'b1);
    do_read("nolast", 32'h0000_3004, 32'h8765_4321, 2'b00, 1'b0, 1'b1);

    // Idle with zero address
    cache_addr_i = 32'd0; arready_i = 1'b1; rvalid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_arvalid", {31'd0, arvalid_o}, 32'd0);
      check("idle_rready", {31'd0, rready_o}, 32'd0);
      check("idle_busy", {31'd0, cache_busy_o}, 32'd1);
    end
    rvalid_i = 1'b0;

    // Reset while in R
    cache_addr_i = 32'h0000_4000;
    tick();
    cache_addr_i = 32'd0;
    tick();
    check("rs_in_r", {31'd0, rready_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_rready", {31'd0, rready_o}, 32'd0);
    check("rs_arvalid", {31'd0, arvalid_o}, 32'd0);
    check("rs_busy", {31'd0, cache_busy_o}, 32'd1);
    check("rs_araddr", araddr_o, 32'd0);
    rvalid_i = 1'b1; rdata_i = 32'h5555_5555;
    tick();
    check("rs_held_busy", {31'd0, cache_busy_o}, 32'd1);
    rvalid_i = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rs_after_arvalid", {31'd0, arvalid_o}, 32'd0);
    do_read("post_rst", 32'h0000_0200, 32'hA5A5_5A5A, 2'b00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
